booth_job_sequencer: RTL and testbench

Issue and collect stage wrapped around the radix-4 Booth multiplier core (controller plus datapath).
- Accepts signed W-bit operand pairs through a valid/ready port and buffers them in a DEPTH-entry FIFO.
- Launches one job at a time into the core with a single-cycle start pulse and tracks the core's busy/ready outputs.
- Captures the 2W-bit product and presents it on a valid/ready result port.

---
 rtl/booth_seq_pkg.sv | 15 +
 rtl/booth_op_fifo.sv | 52 +++++
 rtl/booth_job_sequencer.sv | 116 +++++++++++
 tb/tb_booth_job_sequencer.sv | 445 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/booth_seq_pkg.sv
// Shared types and default parameters for the Booth job sequencer slice.
package booth_seq_pkg;

  localparam int W_DEF       = 16;  // operand width; the core runs W/2 iterations
  localparam int DEPTH_DEF   = 4;   // operand FIFO entries, power of two
  localparam int TIMEOUT_DEF = 4;   // cycles allowed for busy to rise after a start

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_BUSY,
    S_WAIT_DONE
  } state_t;

endpackage

// File: rtl/booth_op_fifo.sv
// Synchronous operand FIFO: wrap-around read/write pointers plus an occupancy
// count. dout always shows the head entry; pop simply advances past it.
module booth_op_fifo
  import booth_seq_pkg::*;
#(
  parameter int DW    = 2 * W_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic [DW-1:0]                din,
  output logic [DW-1:0]                dout,
  output logic [$clog2(DEPTH+1)-1:0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  // Guard against overflow/underflow so a misbehaving caller cannot corrupt the count.
  assign do_push = push && (level != LW'(DEPTH));
  assign do_pop  = pop && (level != '0);
  assign dout    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      level <= level + LW'(1);
      else if (do_pop && !do_push) level <= level - LW'(1);
    end
  end

  // Entry storage write port.
  // NOTE: storage is not reset; the occupancy count alone decides which words are live, which keeps this a plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/booth_job_sequencer.sv
// Issue/collect stage around the radix-4 Booth multiplier core: buffers operand
// pairs, launches one job at a time with a start pulse, watches busy for a
// timeout, and holds the product on a valid/ready result port. Data bits pass
// through untouched; signed interpretation belongs to the core.
module booth_job_sequencer
  import booth_seq_pkg::*;
#(
  parameter int W       = W_DEF,
  parameter int DEPTH   = DEPTH_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [W-1:0]                 in_a,
  input  logic [W-1:0]                 in_b,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [2*W-1:0]               out_p,
  output logic                         mul_start,
  output logic [W-1:0]                 mul_a,
  output logic [W-1:0]                 mul_b,
  input  logic                         mul_busy,
  input  logic                         mul_ready,
  input  logic [2*W-1:0]               mul_p,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         err
);

  localparam int LW = $clog2(DEPTH + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  state_t          state;
  logic [TW-1:0]   to_cnt;
  logic            push;
  logic            pop;
  logic [2*W-1:0]  fifo_dout;

  // in_ready comes from the registered level only, so a same-cycle pop never frees a slot for this push.
  assign in_ready = (level < LW'(DEPTH));
  assign push     = in_valid && in_ready;
  // Issue only when the core is idle and no earlier result is still waiting to be taken.
  assign pop      = (state == S_IDLE) && (level != '0) && mul_ready && !out_valid;

  booth_op_fifo #(
    .DW    (2 * W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   ({in_a, in_b}),
    .dout  (fifo_dout),
    .level (level)
  );

  // Job sequencing FSM with registered start pulse, operands, result and error flag.
  // NOTE: every register here uses <= so each one samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      to_cnt    <= '0;
      mul_start <= 1'b0;
      mul_a     <= '0;
      mul_b     <= '0;
      out_valid <= 1'b0;
      out_p     <= '0;
      err       <= 1'b0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;

      case (state)
        S_IDLE: begin
          if (pop) begin
            mul_a     <= fifo_dout[2*W-1:W];
            mul_b     <= fifo_dout[W-1:0];
            mul_start <= 1'b1;
            state     <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          // The start cycle itself counts toward the busy timeout.
          mul_start <= 1'b0;
          to_cnt    <= TW'(1);
          state     <= S_WAIT_BUSY;
        end

        S_WAIT_BUSY: begin
          if (mul_busy) begin
            state <= S_WAIT_DONE;
          end else if (to_cnt >= TW'(TIMEOUT - 1)) begin
            // Core never acknowledged: flag it and drop the job without a result.
            err   <= 1'b1;
            state <= S_IDLE;
          end else begin
            to_cnt <= to_cnt + TW'(1);
          end
        end

        S_WAIT_DONE: begin
          if (!mul_busy) begin
            out_p     <= mul_p;
            out_valid <= 1'b1;
            state     <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_job_sequencer.sv
// Self-checking bench for booth_job_sequencer. A behavioural Booth core model
// answers start pulses after a fixed number of busy cycles; expected products
// come from plain signed multiplication of the accepted operand pairs.
module tb_booth_job_sequencer;

  localparam int W       = 16;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 4;
  localparam int LW      = $clog2(DEPTH + 1);
  localparam int CORE_BUSY_CYCLES = W / 2 + 1;  // LOAD plus W/2 COUNT cycles

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [W-1:0]   in_a = '0;
  logic [W-1:0]   in_b = '0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [2*W-1:0] out_p;
  logic           mul_start;
  logic [W-1:0]   mul_a;
  logic [W-1:0]   mul_b;
  logic           mul_busy = 1'b0;
  logic           mul_ready = 1'b1;
  logic [2*W-1:0] mul_p = '0;
  logic [LW-1:0]  level;
  logic           err;

  int n_cmp = 0;
  int n_bad = 0;
  int cycle = 0;
  int n_out = 0;
  logic [2*W-1:0] exp_q[$];
  int             start_q[$];

  logic           core_dead = 1'b0;
  int             core_cnt = 0;
  logic [W-1:0]   core_a = '0;
  logic [W-1:0]   core_b = '0;

  always #5 clk = ~clk;

  booth_job_sequencer #(
    .W(W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_p(out_p),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
    .mul_busy(mul_busy), .mul_ready(mul_ready), .mul_p(mul_p),
    .level(level), .err(err)
  );

  function automatic logic [2*W-1:0] ref_prod(input logic [W-1:0] a, input logic [W-1:0] b);
    int sa;
    int sb;
    sa = int'($signed(a));
    sb = int'($signed(b));
    return 32'(sa * sb);
  endfunction

  // Behavioural core: busy for LOAD + W/2 COUNT cycles, product valid once idle, garbage while busy.
  always @(posedge clk) begin
    if (rst) begin
      mul_busy  <= 1'b0;
      mul_ready <= 1'b1;
      mul_p     <= '0;
      core_cnt  <= 0;
    end else if (!core_dead) begin
      if (!mul_busy && mul_start) begin
        mul_busy  <= 1'b1;
        mul_ready <= 1'b0;
        core_cnt  <= CORE_BUSY_CYCLES;
        core_a    <= mul_a;
        core_b    <= mul_b;
      end else if (mul_busy) begin
        core_cnt <= core_cnt - 1;
        if (core_cnt == 1) begin
          mul_busy  <= 1'b0;
          mul_ready <= 1'b1;
          mul_p     <= ref_prod(core_a, core_b);
        end else begin
          mul_p <= 32'($urandom);
        end
      end
    end
  end

  // Book the handshakes that the coming edge will perform, then move to the next mid-cycle point.
  task automatic tick();
    logic [2*W-1:0] e;
    if (!rst) begin
      if (mul_start) start_q.push_back(cycle);
      if (in_valid && in_ready) exp_q.push_back(ref_prod(in_a, in_b));
      if (out_valid && out_ready) begin
        n_out++;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL scoreboard: unexpected product %h with nothing outstanding", out_p);
        end else begin
          e = exp_q.pop_front();
          if (out_p !== e) begin
            n_bad++;
            $display("FAIL scoreboard: out_p=%h expected %h", out_p, e);
          end
        end
      end
    end
    @(negedge clk);
    cycle++;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    exp_q.delete();
    start_q.delete();
  endtask

  task automatic drain(input int n);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (n) tick();
  endtask

  // Push one pair into an idle DUT and wait (bounded) for its product.
  task automatic run_job(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [2*W-1:0] expv, output int lat);
    int p0;
    bit seen;
    out_ready = 1'b1;
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    p0 = cycle;
    tick();
    in_valid = 1'b0;
    seen = 1'b0;
    lat = -1;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (out_valid) begin
        seen = 1'b1;
        lat = cycle - p0;
      end else begin
        tick();
      end
    end
    n_cmp++;
    if (!seen) begin
      n_bad++;
      $display("FAIL job_timeout: no out_valid for %h*%h within 40 cycles", a, b);
    end else if (out_p !== expv) begin
      n_bad++;
      $display("FAIL job_product: %h*%h gave %h expected %h", a, b, out_p, expv);
    end
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({out_valid, in_ready, mul_start, err} !== 4'b0100 || level !== '0) begin
      n_bad++;
      $display("FAIL reset_ctrl: valid/ready/start/err=%b level=%0d expected 0100 level=0",
               {out_valid, in_ready, mul_start, err}, level);
    end
    n_cmp++;
    if (out_p !== '0 || mul_a !== '0 || mul_b !== '0) begin
      n_bad++;
      $display("FAIL reset_data: out_p=%h mul_a=%h mul_b=%h expected all zero", out_p, mul_a, mul_b);
    end
  endtask

  task automatic test_single();
    int p0;
    int lat;
    drain(5);
    start_q.delete();
    p0 = cycle;
    run_job(16'h0003, 16'h0005, 32'h0000000F, lat);
    n_cmp++;
    if (lat !== 13) begin
      n_bad++;
      $display("FAIL single_latency: %0d cycles expected 13", lat);
    end
    n_cmp++;
    if (start_q.size() != 1 || start_q[0] != p0 + 2) begin
      n_bad++;
      $display("FAIL single_start: %0d pulses (first at +%0d) expected 1 at +2",
               start_q.size(), (start_q.size() > 0) ? start_q[0] - p0 : -1);
    end
  endtask

  task automatic test_signed();
    int lat;
    logic [W-1:0] edge_v [4];
    logic [W-1:0] a;
    logic [W-1:0] b;
    edge_v[0] = 16'h7FFF;
    edge_v[1] = 16'h8000;
    edge_v[2] = 16'hFFFF;
    edge_v[3] = 16'h0001;
    drain(3);
    run_job(16'hFFFE, 16'h0007, 32'hFFFFFFF2, lat);
    run_job(16'h8000, 16'h8000, 32'h40000000, lat);
    for (int i = 0; i < 8; i++) begin
      a = (i % 2 == 0) ? edge_v[$urandom_range(0, 3)] : 16'($urandom);
      b = (i < 4) ? edge_v[$urandom_range(0, 3)] : 16'($urandom);
      run_job(a, b, ref_prod(a, b), lat);
    end
  endtask

  task automatic test_back_to_back();
    int n0;
    bit gap_bad;
    drain(5);
    start_q.delete();
    n0 = n_out;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_a = 16'($urandom);
      in_b = 16'($urandom);
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    drain(70);
    gap_bad = (start_q.size() != 4);
    for (int i = 1; i < start_q.size(); i++)
      if (start_q[i] - start_q[i-1] != 13) gap_bad = 1'b1;
    n_cmp++;
    if (gap_bad) begin
      n_bad++;
      $display("FAIL b2b_throughput: %0d starts, first gap %0d, expected 4 starts 13 apart",
               start_q.size(), (start_q.size() > 1) ? start_q[1] - start_q[0] : -1);
    end
    n_cmp++;
    if (n_out - n0 != 4 || exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL b2b_count: %0d products, %0d outstanding, expected 4 and 0",
               n_out - n0, exp_q.size());
    end
  endtask

  task automatic test_full();
    bit [5:0] rdy;
    int n0;
    drain(20);
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      in_a = 16'($urandom);
      in_b = 16'($urandom);
      in_valid = 1'b1;
      rdy[i] = in_ready;
      tick();
    end
    in_valid = 1'b0;
    n_cmp++;
    if (rdy !== 6'b011111) begin
      n_bad++;
      $display("FAIL full_accept: in_ready per offer (bit0 first)=%b expected 011111", rdy);
    end
    n_cmp++;
    if (level !== LW'(4) || in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL full_level: level=%0d in_ready=%b expected 4 and 0", level, in_ready);
    end
    n0 = n_out;
    drain(90);
    n_cmp++;
    if (n_out - n0 != 5 || exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL full_drain: %0d products, %0d outstanding, expected 5 and 0",
               n_out - n0, exp_q.size());
    end
  endtask

  task automatic test_backpressure();
    logic [2*W-1:0] p;
    logic [LW-1:0]  lv;
    bit stable_bad, start_bad, level_bad, valid_bad;
    drain(20);
    out_ready = 1'b0;
    in_a = 16'($urandom);
    in_b = 16'($urandom);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 20 && !out_valid; i++) tick();
    in_a = 16'($urandom);
    in_b = 16'($urandom);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    p  = out_p;
    lv = level;
    stable_bad = 1'b0;
    start_bad  = 1'b0;
    level_bad  = 1'b0;
    valid_bad  = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (out_p !== p)     stable_bad = 1'b1;
      if (mul_start !== 1'b0) start_bad = 1'b1;
      if (level !== lv)    level_bad  = 1'b1;
      if (out_valid !== 1'b1) valid_bad = 1'b1;
      tick();
    end
    n_cmp++;
    if (valid_bad || stable_bad) begin
      n_bad++;
      $display("FAIL bp_hold: out_valid dropped=%b out_p changed=%b expected both 0", valid_bad, stable_bad);
    end
    n_cmp++;
    if (start_bad || level_bad || lv !== LW'(1)) begin
      n_bad++;
      $display("FAIL bp_issue: start seen=%b level moved=%b level=%0d expected 0 0 1",
               start_bad, level_bad, lv);
    end
    drain(40);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL bp_drain: %0d products outstanding expected 0", exp_q.size());
    end
  endtask

  task automatic test_timeout();
    int s;
    bit got_valid;
    bit err_lost;
    drain(20);
    core_dead = 1'b1;
    start_q.delete();
    in_a = 16'($urandom);
    in_b = 16'($urandom);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 10 && start_q.size() == 0; i++) tick();
    n_cmp++;
    if (start_q.size() == 0) begin
      n_bad++;
      $display("FAIL to_start: no mul_start within 10 cycles");
    end else begin
      s = start_q[0];
      while (cycle < s + 3) tick();
      if (err !== 1'b0) begin
        n_bad++;
        $display("FAIL to_early: err=%b at start+3 expected 0", err);
      end
      tick();
      n_cmp++;
      if (err !== 1'b1) begin
        n_bad++;
        $display("FAIL to_err: err=%b at start+4 expected 1", err);
      end
    end
    got_valid = 1'b0;
    err_lost  = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid) got_valid = 1'b1;
      if (err !== 1'b1) err_lost = 1'b1;
      tick();
    end
    n_cmp++;
    if (got_valid || err_lost || level !== '0) begin
      n_bad++;
      $display("FAIL to_drop: out_valid seen=%b err lost=%b level=%0d expected 0 0 0",
               got_valid, err_lost, level);
    end
    exp_q.delete();
    core_dead = 1'b0;
    do_reset();
    n_cmp++;
    if (err !== 1'b0) begin
      n_bad++;
      $display("FAIL to_clear: err=%b after rst expected 0", err);
    end
  endtask

  task automatic test_reset_mid();
    int p0;
    int lat;
    logic [W-1:0] a;
    logic [W-1:0] b;
    drain(20);
    out_ready = 1'b1;
    p0 = cycle;
    for (int i = 0; i < 3; i++) begin
      in_a = 16'($urandom);
      in_b = 16'($urandom);
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    while (cycle < p0 + 6) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    start_q.delete();
    n_cmp++;
    if (level !== '0 || {out_valid, in_ready, mul_start} !== 3'b010) begin
      n_bad++;
      $display("FAIL rst_mid: level=%0d valid/ready/start=%b expected 0 and 010",
               level, {out_valid, in_ready, mul_start});
    end
    tick();
    a = 16'($urandom);
    b = 16'($urandom);
    run_job(a, b, ref_prod(a, b), lat);
    n_cmp++;
    if (lat !== 13) begin
      n_bad++;
      $display("FAIL rst_fresh_latency: %0d cycles expected 13", lat);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_single();
    test_signed();
    test_back_to_back();
    test_full();
    test_backpressure();
    test_timeout();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
